// File: rtl/pipeline_ctrl.sv
// LC-3b pipeline sequencer: per-stage load/bubble control with
// load-use interlock, redirect squash and memory wait handling.
module pipeline_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_req,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic [REG_W-1:0]      id_sr1,
  input  logic [REG_W-1:0]      id_sr2,
  input  logic                  id_sr1_used,
  input  logic                  id_sr2_used,
  input  logic [REG_W-1:0]      ex_dest,
  input  logic                  ex_is_load,
  input  logic                  redirect,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_bubble,
  output logic                  pc_load,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int N = NUM_STAGES;

  localparam logic [N-1:0] ALL     = '1;
  localparam logic [N-1:0] SQ_BUB  = {1'b0, {(N-2){1'b1}}, 1'b0};
  localparam logic [N-1:0] LU_LOAD = {{(N-2){1'b1}}, 2'b00};
  localparam logic [N-1:0] LU_BUB  = {{(N-3){1'b0}}, 3'b100};
  localparam logic [N-1:0] IW_LOAD = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0] IW_BUB  = {{(N-2){1'b0}}, 2'b10};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    IWAIT  = 2'd2,
    SQUASH = 2'd3
  } state_t;

  state_t cur, nxt;
  logic pend, pend_nxt;
  logic drop, drop_nxt;
  logic [CNT_W-1:0] cnt;

  logic dwait, take, luse, iwait;
  logic hit1, hit2;
  logic lu_only, iw_only;

  assign hit1  = id_sr1_used & (id_sr1 == ex_dest);
  assign hit2  = id_sr2_used & (id_sr2 == ex_dest);
  assign dwait = dmem_req & ~dmem_resp;
  assign take  = ~dwait & (redirect | pend);
  assign luse  = ex_is_load & (hit1 | hit2);
  // a stale fetch response after a redirect does not end the wait
  assign iwait = imem_req & (~imem_resp | drop);

  assign lu_only = luse & ~dwait & ~take;
  assign iw_only = iwait & ~dwait & ~take & ~luse;

  always_comb begin
    stage_load   = ALL;
    stage_bubble = '0;
    nxt          = RUN;
    pend_nxt     = pend;
    drop_nxt     = imem_resp ? 1'b0 : drop;
    unique case (1'b1)
      dwait: begin
        stage_load = '0;
        nxt        = DWAIT;
        pend_nxt   = pend | redirect;
      end
      take: begin
        stage_bubble = SQ_BUB;
        nxt          = SQUASH;
        pend_nxt     = 1'b0;
        if (imem_req & ~imem_resp)
          drop_nxt = 1'b1;
      end
      lu_only: begin
        stage_load   = LU_LOAD;
        stage_bubble = LU_BUB;
        nxt          = iwait ? IWAIT : RUN;
      end
      iw_only: begin
        stage_load   = IW_LOAD;
        stage_bubble = IW_BUB;
        nxt          = IWAIT;
      end
      default: ;
    endcase
    if (!rst_n) begin
      stage_load   = ALL;
      stage_bubble = ALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur  <= RUN;
      pend <= 1'b0;
      drop <= 1'b0;
      cnt  <= '0;
    end else begin
      cur  <= nxt;
      pend <= pend_nxt;
      drop <= drop_nxt;
      if (~&stage_load && ~&cnt)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign pc_load      = stage_load[0];
  assign state        = cur;
  assign stall_cycles = cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized check of pipeline_ctrl against a
// rule-level reference model (5 stages, 4-bit stall counter).
module tb_pipeline_ctrl;

  localparam int N = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_req, imem_resp;
  logic dmem_req, dmem_resp;
  logic [2:0] id_sr1, id_sr2, ex_dest;
  logic id_sr1_used, id_sr2_used;
  logic ex_is_load, redirect;
  logic [N-1:0] stage_load, stage_bubble;
  logic pc_load;
  logic [1:0] state;
  logic [CW-1:0] stall_cycles;

  int compared = 0;
  int mismatched = 0;

  int m_state;
  bit m_pend, m_drop;
  int m_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .NUM_STAGES(N),
    .REG_W(3),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_resp(imem_resp),
    .dmem_req(dmem_req),
    .dmem_resp(dmem_resp),
    .id_sr1(id_sr1),
    .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used),
    .id_sr2_used(id_sr2_used),
    .ex_dest(ex_dest),
    .ex_is_load(ex_is_load),
    .redirect(redirect),
    .stage_load(stage_load),
    .stage_bubble(stage_bubble),
    .pc_load(pc_load),
    .state(state),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input int got, input int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1;
    imem_req = 1'b0; imem_resp = 1'b0;
    dmem_req = 1'b0; dmem_resp = 1'b0;
    id_sr1 = 3'd0; id_sr2 = 3'd0; ex_dest = 3'd0;
    id_sr1_used = 1'b0; id_sr2_used = 1'b0;
    ex_is_load = 1'b0; redirect = 1'b0;
  endtask

  // Apply current inputs for one cycle: check, then clock the model.
  task automatic step(input string tag);
    int all, el, eb, nst;
    bit dw, tk, lu, iw;
    all = (1 << N) - 1;
    #1;
    dw = dmem_req && !dmem_resp;
    tk = !dw && (redirect || m_pend);
    lu = ex_is_load && ((id_sr1_used && id_sr1 == ex_dest) ||
                        (id_sr2_used && id_sr2 == ex_dest));
    iw = imem_req && (!imem_resp || m_drop);
    if (!rst_n) begin
      el = all; eb = all;
    end else if (dw) begin
      el = 0; eb = 0;
    end else if (tk) begin
      el = all; eb = (1 << (N - 1)) - 2;
    end else if (lu) begin
      el = all - 3; eb = 4;
    end else if (iw) begin
      el = all - 1; eb = 2;
    end else begin
      el = all; eb = 0;
    end
    chk({tag, ".load"}, int'(stage_load), el);
    chk({tag, ".bubble"}, int'(stage_bubble), eb);
    chk({tag, ".pc_load"}, int'(pc_load), el % 2);
    chk({tag, ".state"}, int'(state), m_state);
    chk({tag, ".stall"}, int'(stall_cycles), m_cnt);
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_pend = 0; m_drop = 0; m_cnt = 0;
    end else begin
      if (el != all && m_cnt < (1 << CW) - 1) m_cnt++;
      nst = dw ? 1 : tk ? 3 : iw ? 2 : 0;
      m_state = nst;
      if (dw) m_pend = m_pend || redirect;
      else if (tk) m_pend = 0;
      if (imem_resp) m_drop = 0;
      if (tk && imem_req && !imem_resp) m_drop = 1;
    end
    #1;
  endtask

  initial begin
    m_state = 0; m_pend = 0; m_drop = 0; m_cnt = 0;
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    repeat (3) step("idle");

    dmem_req = 1'b1;
    repeat (3) step("dwait");
    dmem_resp = 1'b1;
    step("dresp");
    idle();
    step("post_d");

    ex_is_load = 1'b1; ex_dest = 3'd2;
    id_sr1 = 3'd2; id_sr1_used = 1'b1;
    step("loaduse");
    idle();
    step("post_lu");

    redirect = 1'b1;
    step("redir");
    idle();
    step("squash");
    step("back_run");

    dmem_req = 1'b1; redirect = 1'b1;
    step("dw_redir");
    redirect = 1'b0;
    step("dw_hold");
    dmem_resp = 1'b1;
    step("dw_resp");
    idle();
    step("post_pend");

    imem_req = 1'b1;
    repeat (2) step("iwait");
    redirect = 1'b1;
    step("iw_redir");
    redirect = 1'b0; imem_resp = 1'b1;
    step("stale_resp");
    step("real_resp");
    idle();
    step("post_iw");

    dmem_req = 1'b1;
    repeat (20) step("sat");
    idle();
    repeat (2) step("sat_hold");

    repeat (500) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      imem_req    = $urandom_range(0, 2) != 0;
      imem_resp   = $urandom_range(0, 1) != 0;
      dmem_req    = $urandom_range(0, 3) == 0;
      dmem_resp   = $urandom_range(0, 1) != 0;
      id_sr1      = 3'($urandom_range(0, 7));
      id_sr2      = 3'($urandom_range(0, 7));
      ex_dest     = 3'($urandom_range(0, 7));
      id_sr1_used = $urandom_range(0, 1) != 0;
      id_sr2_used = $urandom_range(0, 1) != 0;
      ex_is_load  = $urandom_range(0, 2) == 0;
      redirect    = $urandom_range(0, 5) == 0;
      step("rand");
    end

    idle();
    rst_n = 1'b0;
    step("final_rst");
    rst_n = 1'b1;
    step("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
